switch_event_generator: RTL and testbench

Upstream input stage for the two-digit push-button counter. Turns one raw, bouncy, asynchronous push-button into a debounced level and single-cycle event pulses: press, release, and hold-to-repeat. The counter/display logic downstream advances on `o_Press` or `o_Repeat` instead of doing its own edge detection. This gives auto-increment while the button is held.

---
 rtl/switch_event_pkg.sv | 18 +
 rtl/switch_debounce_filter.sv | 44 ++++
 rtl/switch_event_generator.sv | 142 ++++++++++++++
 tb/tb_switch_event_generator.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/switch_event_pkg.sv
// Shared types and 25 MHz default timing for the push-button event generator.
package switch_event_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_WAIT = 2'd1,
        REPEATING = 2'd2
    } state_t;

    localparam int DEF_DEBOUNCE_LIMIT = 250000;    // 10 ms
    localparam int DEF_REPEAT_DELAY   = 12500000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD  = 2500000;   // 100 ms

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/switch_debounce_filter.sv
// Two-flop synchronizer followed by a restart-on-glitch debounce counter.
module switch_debounce_filter
    import switch_event_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch
);

    localparam int CW = $clog2(DEBOUNCE_LIMIT);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_switch;
    logic [CW-1:0] r_count;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_switch <= 1'b0;
            r_count  <= '0;
        end else begin
            r_sync1 <= i_Switch;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_switch) begin
                if (r_count == CW'(DEBOUNCE_LIMIT - 1)) begin
                    r_switch <= ~r_switch;
                    r_count  <= '0;
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end else begin
                r_count <= '0;
            end
        end
    end

    assign o_Switch = r_switch;

endmodule

// File: rtl/switch_event_generator.sv
// Debounced push-button to press / release / auto-repeat pulses.
//   state     | meaning
//   IDLE      | button released, waiting for a debounced rise
//   HOLD_WAIT | pressed, counting towards the first repeat
//   REPEATING | held past the initial delay, repeating every period
module switch_event_generator
    import switch_event_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Repeat,
    output logic o_Held
);

    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));

    logic          w_switch;
    logic          w_rise;
    logic          w_fall;
    logic          w_delay_tc;
    logic          w_period_tc;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [RW-1:0] r_count;
    logic [RW-1:0] w_count_nxt;
    logic          r_switch;
    logic          r_press;
    logic          r_release;
    logic          r_repeat;
    logic          r_held;
    logic          w_press_nxt;
    logic          w_release_nxt;
    logic          w_repeat_nxt;
    logic          w_held_nxt;

    switch_debounce_filter #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_debounce (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Switch(i_Switch),
        .o_Switch(w_switch)
    );

    // r_switch re-times the filter output so o_Switch lines up with the pulses.
    assign w_rise      = w_switch & ~r_switch;
    assign w_fall      = ~w_switch & r_switch;
    assign w_delay_tc  = (r_count == RW'(REPEAT_DELAY - 1));
    assign w_period_tc = (r_count == RW'(REPEAT_PERIOD - 1));

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_switch  <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_switch  <= w_switch;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_repeat  <= w_repeat_nxt;
            r_held    <= w_held_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_rise) w_state_nxt = HOLD_WAIT;
            HOLD_WAIT: begin
                if (w_fall)          w_state_nxt = IDLE;
                else if (w_delay_tc) w_state_nxt = REPEATING;
            end
            REPEATING: if (w_fall) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // Release is checked first so it suppresses a coincident repeat tick.
    always_comb begin
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_repeat_nxt  = 1'b0;
        w_held_nxt    = r_held;
        w_count_nxt   = r_count;
        case (r_state)
            IDLE: begin
                w_count_nxt = '0;
                w_press_nxt = w_rise;
            end
            HOLD_WAIT: begin
                if (w_fall) begin
                    w_release_nxt = 1'b1;
                    w_held_nxt    = 1'b0;
                    w_count_nxt   = '0;
                end else if (w_delay_tc) begin
                    w_repeat_nxt = 1'b1;
                    w_held_nxt   = 1'b1;
                    w_count_nxt  = '0;
                end else begin
                    w_count_nxt = r_count + RW'(1);
                end
            end
            REPEATING: begin
                if (w_fall) begin
                    w_release_nxt = 1'b1;
                    w_held_nxt    = 1'b0;
                    w_count_nxt   = '0;
                end else if (w_period_tc) begin
                    w_repeat_nxt = 1'b1;
                    w_count_nxt  = '0;
                end else begin
                    w_count_nxt = r_count + RW'(1);
                end
            end
            default: begin
                w_held_nxt  = 1'b0;
                w_count_nxt = '0;
            end
        endcase
    end

    assign o_Switch  = r_switch;
    assign o_Press   = r_press;
    assign o_Release = r_release;
    assign o_Repeat  = r_repeat;
    assign o_Held    = r_held;

endmodule

// File: tb/tb_switch_event_generator.sv
// Scoreboard bench: stimulus pushes expected events, a negedge monitor pops and compares them.
module tb_switch_event_generator;

    localparam int DL = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int LAT = DL + 3;  // negedge of input change to visible pulse

    localparam logic [2:0] EV_PRESS   = 3'b100;
    localparam logic [2:0] EV_RELEASE = 3'b010;
    localparam logic [2:0] EV_REPEAT  = 3'b001;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
        logic       sw;
        logic       held;
    } ev_t;

    logic i_Clk = 1'b0;
    logic i_Rst = 1'b1;
    logic i_Switch = 1'b0;
    logic o_Switch, o_Press, o_Release, o_Repeat, o_Held;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;
    ev_t sb[$];

    switch_event_generator #(
        .DEBOUNCE_LIMIT(DL),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Switch (i_Switch),
        .o_Switch (o_Switch),
        .o_Press  (o_Press),
        .o_Release(o_Release),
        .o_Repeat (o_Repeat),
        .o_Held   (o_Held)
    );

    always #5 i_Clk = ~i_Clk;
    always @(posedge i_Clk) cyc++;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [2:0] k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.sw   = (k != EV_RELEASE);
        e.held = (k == EV_REPEAT);
        sb.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sw"},   int'(o_Switch),  0);
        chk({tag, "_prs"},  int'(o_Press),   0);
        chk({tag, "_rel"},  int'(o_Release), 0);
        chk({tag, "_rpt"},  int'(o_Repeat),  0);
        chk({tag, "_held"}, int'(o_Held),    0);
    endtask

    always @(negedge i_Clk) begin
        if (o_Press || o_Release || o_Repeat) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", int'({o_Press, o_Release, o_Repeat}), 0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("ev_kind",  int'({o_Press, o_Release, o_Repeat}), int'(e.kind));
                chk("ev_cycle", cyc, e.cyc);
                chk("ev_sw",    int'(o_Switch), int'(e.sw));
                chk("ev_held",  int'(o_Held),   int'(e.held));
            end
        end
    end

    initial begin
        int c;
        repeat (3) @(negedge i_Clk);
        chk_all_zero("reset");
        i_Rst = 1'b0;
        repeat (5) @(negedge i_Clk);

        // Clean press, hold with repeats, release timed onto a repeat terminal count.
        c = cyc;
        i_Switch = 1'b1;
        push(c + LAT, EV_PRESS);
        for (int k = 0; k < 7; k++) push(c + LAT + RD + k * RP, EV_REPEAT);
        push(c + LAT + RD + 7 * RP, EV_RELEASE);
        repeat (LAT + RD + 7 * RP - LAT) @(negedge i_Clk);
        i_Switch = 1'b0;
        repeat (15) @(negedge i_Clk);

        // Bounce 1,0,1,0 then a short tap: press, release 5 cycles later, no repeat.
        i_Switch = 1'b1; @(negedge i_Clk);
        i_Switch = 1'b0; @(negedge i_Clk);
        i_Switch = 1'b1; @(negedge i_Clk);
        i_Switch = 1'b0; @(negedge i_Clk);
        c = cyc;
        i_Switch = 1'b1;
        push(c + LAT, EV_PRESS);
        push(c + LAT + 5, EV_RELEASE);
        repeat (5) @(negedge i_Clk);
        i_Switch = 1'b0;
        repeat (20) @(negedge i_Clk);

        // Reset while repeating with the button still held.
        c = cyc;
        i_Switch = 1'b1;
        push(c + LAT, EV_PRESS);
        push(c + LAT + RD, EV_REPEAT);
        push(c + LAT + RD + RP, EV_REPEAT);
        repeat (LAT + RD + RP + 1) @(negedge i_Clk);
        i_Rst = 1'b1;
        @(negedge i_Clk);
        chk_all_zero("midrst");
        chk("midrst_pending", sb.size(), 0);
        i_Rst = 1'b0;
        c = cyc;
        push(c + LAT, EV_PRESS);
        push(c + LAT + 9, EV_RELEASE);
        repeat (9) @(negedge i_Clk);
        i_Switch = 1'b0;
        repeat (15) @(negedge i_Clk);

        chk("sb_empty", sb.size(), 0);
        chk("final_sw", int'(o_Switch), 0);
        chk("final_held", int'(o_Held), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
